// File: rtl/race_pkg.sv
// ---------------------------------------------------------------------------
// Module : race_pkg
// Brief  : State encoding shared by the race start sequencer.
// Rev    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package race_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE     = 2'd0,
    ST_COUNTING = 2'd1,
    ST_GO       = 2'd2,
    ST_RACING   = 2'd3
  } race_state_e;

endpackage

`default_nettype wire

// File: rtl/race_start_sequencer_step_prescaler.sv
// ---------------------------------------------------------------------------
// Module : step_prescaler
// Brief  : Divides clk into one tick every TICK_CLK_COUNT enabled cycles.
// Rev    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module step_prescaler #(
  parameter int TICK_CLK_COUNT = 50000000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int PW = $clog2(TICK_CLK_COUNT);
  localparam logic [PW-1:0] LAST = PW'(TICK_CLK_COUNT - 1);

  logic [PW-1:0] count_q;
  logic [PW-1:0] count_d;

  // Clear wins over enable so an aborted step can never produce a tick.
  assign tick = enable && !clear && (count_q == LAST);

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = (count_q == LAST) ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/race_start_sequencer.sv
// ---------------------------------------------------------------------------
// Module : race_start_sequencer
// Brief  : Lobby controller: waits for ready players, counts down, strobes go.
// Rev    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module race_start_sequencer
  import race_pkg::*;
#(
  parameter int N_PLAYERS        = 4,
  parameter int MIN_READY        = 4,
  parameter int TICK_CLK_COUNT   = 50000000,
  parameter int COUNT_START      = 7,
  parameter int CNT_W            = 3,
  parameter int ABORT_ON_UNREADY = 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [N_PLAYERS-1:0]             ready,
  input  logic                             race_over,
  output logic                             is_in_menu,
  output logic [CNT_W-1:0]                 countdown,
  output logic                             go,
  output logic                             activity,
  output logic [$clog2(N_PLAYERS+1)-1:0]   ready_count
);

  localparam int RC_W = $clog2(N_PLAYERS + 1);
  localparam logic [RC_W-1:0]  MIN_READY_C   = RC_W'(MIN_READY);
  localparam logic [CNT_W-1:0] COUNT_START_C = CNT_W'(COUNT_START);

  if (MIN_READY < 1 || MIN_READY > N_PLAYERS) begin : g_bad_min_ready
    $error("MIN_READY must be in 1..N_PLAYERS");
  end
  if (COUNT_START < 1 || COUNT_START > (2**CNT_W) - 1) begin : g_bad_count_start
    $error("COUNT_START must be in 1..2**CNT_W-1");
  end
  if (TICK_CLK_COUNT < 2) begin : g_bad_tick
    $error("TICK_CLK_COUNT must be at least 2");
  end

  function automatic logic [RC_W-1:0] popcount(input logic [N_PLAYERS-1:0] v);
    logic [RC_W-1:0] n;
    n = '0;
    for (int i = 0; i < N_PLAYERS; i++) begin
      n = n + RC_W'(v[i]);
    end
    return n;
  endfunction

  race_state_e      state_q, state_d;
  logic [CNT_W-1:0] countdown_q, countdown_d;
  logic             go_q, go_d;
  logic             activity_q, activity_d;
  logic             in_menu_q, in_menu_d;
  logic             enough_ready;
  logic             abort;
  logic             tick;

  assign ready_count  = popcount(ready);
  assign enough_ready = (ready_count >= MIN_READY_C);
  assign abort        = (ABORT_ON_UNREADY != 0) && (state_q == ST_COUNTING) && !enough_ready;

  step_prescaler #(
    .TICK_CLK_COUNT(TICK_CLK_COUNT)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .clear ((state_q != ST_COUNTING) || abort),
    .enable(state_q == ST_COUNTING),
    .tick  (tick)
  );

  always_comb begin
    state_d     = state_q;
    countdown_d = countdown_q;
    go_d        = 1'b0;
    activity_d  = 1'b0;
    in_menu_d   = in_menu_q;
    case (state_q)
      ST_IDLE: begin
        in_menu_d   = 1'b1;
        countdown_d = '0;
        if (enough_ready) begin
          state_d     = ST_COUNTING;
          countdown_d = COUNT_START_C;
        end
      end
      ST_COUNTING: begin
        if (abort) begin
          state_d     = ST_IDLE;
          countdown_d = '0;
        end else if (tick) begin
          activity_d = 1'b1;
          if (countdown_q > CNT_W'(1)) begin
            countdown_d = countdown_q - 1'b1;
          end else begin
            state_d     = ST_GO;
            countdown_d = '0;
            go_d        = 1'b1;
            in_menu_d   = 1'b0;
          end
        end
      end
      ST_GO: begin
        state_d   = ST_RACING;
        in_menu_d = 1'b0;
      end
      ST_RACING: begin
        if (race_over) begin
          state_d     = ST_IDLE;
          in_menu_d   = 1'b1;
          countdown_d = '0;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        in_menu_d   = 1'b1;
        countdown_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      countdown_q <= '0;
      go_q        <= 1'b0;
      activity_q  <= 1'b0;
      in_menu_q   <= 1'b1;
    end else begin
      state_q     <= state_d;
      countdown_q <= countdown_d;
      go_q        <= go_d;
      activity_q  <= activity_d;
      in_menu_q   <= in_menu_d;
    end
  end

  assign is_in_menu = in_menu_q;
  assign countdown  = countdown_q;
  assign go         = go_q;
  assign activity   = activity_q;

endmodule

`default_nettype wire

// File: tb/tb_race_start_sequencer.sv
// ---------------------------------------------------------------------------
// Module : tb_race_start_sequencer
// Brief  : Directed table, hand sequences and random run against a cycle model.
// Rev    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_race_start_sequencer;

  localparam int TICK = 4;
  localparam int CS   = 3;
  localparam int M_LOBBY = 0, M_COUNT = 1, M_GOING = 2, M_RACE = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // A: MIN_READY=4 with abort; B: MIN_READY=2 without abort
  logic       rst_a, ro_a, menu_a, go_a, act_a;
  logic [3:0] rdy_a;
  logic [2:0] cd_a, rc_a;
  logic       rst_b, ro_b, menu_b, go_b, act_b;
  logic [3:0] rdy_b;
  logic [2:0] cd_b, rc_b;

  race_start_sequencer #(
    .N_PLAYERS(4), .MIN_READY(4), .TICK_CLK_COUNT(TICK), .COUNT_START(CS),
    .CNT_W(3), .ABORT_ON_UNREADY(1)
  ) u_dut_a (
    .clk(clk), .reset(rst_a), .ready(rdy_a), .race_over(ro_a),
    .is_in_menu(menu_a), .countdown(cd_a), .go(go_a), .activity(act_a),
    .ready_count(rc_a)
  );

  race_start_sequencer #(
    .N_PLAYERS(4), .MIN_READY(2), .TICK_CLK_COUNT(TICK), .COUNT_START(CS),
    .CNT_W(3), .ABORT_ON_UNREADY(0)
  ) u_dut_b (
    .clk(clk), .reset(rst_b), .ready(rdy_b), .race_over(ro_b),
    .is_in_menu(menu_b), .countdown(cd_b), .go(go_b), .activity(act_b),
    .ready_count(rc_b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       rst;
    logic [3:0] rdy;
    logic       ro;
    logic [2:0] cd;
    logic       go;
    logic       act;
    logic       menu;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input int n, input logic rst, input logic [3:0] rdy, input logic ro,
                     input logic [2:0] cd, input logic g, input logic act, input logic menu);
    vec_t v;
    v.rst = rst; v.rdy = rdy; v.ro = ro; v.cd = cd; v.go = g; v.act = act; v.menu = menu;
    for (int i = 0; i < n; i++) tbl.push_back(v);
  endtask

  // Reference model: tracks elapsed counting cycles; countdown is derived arithmetically.
  int m_mode[2];
  int m_el[2];

  task automatic model_step(input int i, input logic rst, input logic [3:0] rdy,
                            input logic ro, input int min_rdy, input bit abort_en);
    int pc;
    pc = $countones(rdy);
    if (rst) begin
      m_mode[i] = M_LOBBY;
      m_el[i]   = 0;
    end else begin
      case (m_mode[i])
        M_LOBBY: if (pc >= min_rdy) begin m_mode[i] = M_COUNT; m_el[i] = 0; end
        M_COUNT: begin
          if (abort_en && pc < min_rdy) m_mode[i] = M_LOBBY;
          else begin
            m_el[i]++;
            if (m_el[i] == CS * TICK) m_mode[i] = M_GOING;
          end
        end
        M_GOING: m_mode[i] = M_RACE;
        default: if (ro) m_mode[i] = M_LOBBY;
      endcase
    end
  endtask

  task automatic model_check(input int i, input logic [2:0] cd, input logic g,
                             input logic act, input logic menu);
    int e_cd, e_act;
    e_cd  = (m_mode[i] == M_COUNT) ? CS - m_el[i] / TICK : 0;
    e_act = ((m_mode[i] == M_COUNT && m_el[i] > 0 && m_el[i] % TICK == 0) ||
             m_mode[i] == M_GOING) ? 1 : 0;
    check(i == 0 ? "rnd_a_countdown" : "rnd_b_countdown", 32'(cd), 32'(e_cd));
    check(i == 0 ? "rnd_a_go" : "rnd_b_go", 32'(g), 32'(m_mode[i] == M_GOING));
    check(i == 0 ? "rnd_a_activity" : "rnd_b_activity", 32'(act), 32'(e_act));
    check(i == 0 ? "rnd_a_in_menu" : "rnd_b_in_menu", 32'(menu),
          32'(m_mode[i] == M_LOBBY || m_mode[i] == M_COUNT));
  endtask

  initial begin
    rst_a = 1'b1; rdy_a = 4'hF; ro_a = 1'b0;
    rst_b = 1'b1; rdy_b = 4'h0; ro_b = 1'b0;

    // rst, ready, race_over -> countdown, go, activity, in_menu
    add(2, 1, 4'hF, 0, 0, 0, 0, 1);
    add(4, 0, 4'hF, 0, 3, 0, 0, 1);
    add(1, 0, 4'hF, 0, 2, 0, 1, 1);
    add(3, 0, 4'hF, 0, 2, 0, 0, 1);
    add(1, 0, 4'hF, 0, 1, 0, 1, 1);
    add(3, 0, 4'hF, 0, 1, 0, 0, 1);
    add(1, 0, 4'hF, 0, 0, 1, 1, 0);
    add(1, 0, 4'hF, 1, 0, 0, 0, 0);
    add(1, 0, 4'h0, 1, 0, 0, 0, 1);
    add(2, 0, 4'h0, 1, 0, 0, 0, 1);
    add(4, 0, 4'hF, 0, 3, 0, 0, 1);
    add(1, 0, 4'hF, 0, 2, 0, 1, 1);
    add(1, 0, 4'hF, 0, 2, 0, 0, 1);
    add(4, 0, 4'h7, 0, 0, 0, 0, 1);
    add(4, 0, 4'hF, 0, 3, 0, 0, 1);
    add(1, 0, 4'h7, 0, 0, 0, 0, 1);
    add(1, 0, 4'h7, 0, 0, 0, 0, 1);

    for (int k = 0; k < tbl.size(); k++) begin
      rst_a = tbl[k].rst; rdy_a = tbl[k].rdy; ro_a = tbl[k].ro;
      #1;
      check("tbl_ready_count", 32'(rc_a), 32'($countones(tbl[k].rdy)));
      cyc();
      check($sformatf("tbl[%0d]_countdown", k), 32'(cd_a), 32'(tbl[k].cd));
      check($sformatf("tbl[%0d]_go", k), 32'(go_a), 32'(tbl[k].go));
      check($sformatf("tbl[%0d]_activity", k), 32'(act_a), 32'(tbl[k].act));
      check($sformatf("tbl[%0d]_in_menu", k), 32'(menu_a), 32'(tbl[k].menu));
    end

    // B: no abort when ready drops mid-count
    rst_a = 1'b1;
    rst_b = 1'b0; rdy_b = 4'hF;
    cyc();
    check("noabort_t1_countdown", 32'(cd_b), 32'd3);
    repeat (4) cyc();
    check("noabort_t5_countdown", 32'(cd_b), 32'd2);
    check("noabort_t5_activity", 32'(act_b), 32'd1);
    cyc();
    rdy_b = 4'h1;
    repeat (3) cyc();
    check("noabort_t9_countdown", 32'(cd_b), 32'd1);
    check("noabort_t9_activity", 32'(act_b), 32'd1);
    repeat (4) cyc();
    check("noabort_t13_go", 32'(go_b), 32'd1);
    check("noabort_t13_in_menu", 32'(menu_b), 32'd0);
    check("noabort_t13_countdown", 32'(cd_b), 32'd0);
    cyc();
    check("noabort_t14_go", 32'(go_b), 32'd0);
    check("noabort_t14_in_menu", 32'(menu_b), 32'd0);
    ro_b = 1'b1;
    cyc();
    ro_b = 1'b0;
    check("race_over_in_menu", 32'(menu_b), 32'd1);
    check("race_over_countdown", 32'(cd_b), 32'd0);

    // B: two of four players are enough; reset mid-count
    rdy_b = 4'b0101;
    #1;
    check("min2_ready_count", 32'(rc_b), 32'd2);
    cyc();
    check("min2_start_countdown", 32'(cd_b), 32'd3);
    repeat (4) cyc();
    check("min2_step_countdown", 32'(cd_b), 32'd2);
    rst_b = 1'b1;
    cyc();
    check("reset_mid_countdown", 32'(cd_b), 32'd0);
    check("reset_mid_in_menu", 32'(menu_b), 32'd1);
    check("reset_mid_go", 32'(go_b), 32'd0);
    check("reset_mid_activity", 32'(act_b), 32'd0);
    rst_b = 1'b0;
    cyc();
    check("restart_countdown", 32'(cd_b), 32'd3);
    repeat (3) cyc();
    check("restart_hold_countdown", 32'(cd_b), 32'd3);
    cyc();
    check("restart_step_countdown", 32'(cd_b), 32'd2);

    // Random phase: both instances against the model
    for (int c = 0; c < 3000; c++) begin
      rst_a = (c == 0) || ($urandom_range(0, 299) == 0);
      rst_b = (c == 0) || ($urandom_range(0, 299) == 0);
      rdy_a = ($urandom_range(0, 15) < 15) ? 4'hF : 4'($urandom);
      rdy_b = 4'($urandom);
      ro_a  = ($urandom_range(0, 7) == 0);
      ro_b  = ($urandom_range(0, 7) == 0);
      #1;
      check("rnd_a_ready_count", 32'(rc_a), 32'($countones(rdy_a)));
      check("rnd_b_ready_count", 32'(rc_b), 32'($countones(rdy_b)));
      cyc();
      model_step(0, rst_a, rdy_a, ro_a, 4, 1'b1);
      model_step(1, rst_b, rdy_b, ro_b, 2, 1'b0);
      model_check(0, cd_a, go_a, act_a, menu_a);
      model_check(1, cd_b, go_b, act_b, menu_b);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
